// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: immediate-type
// encodings, handshake state encoding and the registered result record.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  // Result record is sized for the widest legal configuration; TAG_W <= 16.
  localparam int IMM_XLEN_MAX = 64;
  localparam int IMM_TAG_MAX  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

  typedef struct packed {
    logic                    illegal;
    logic [IMM_TAG_MAX-1:0]  tag;
    logic [IMM_XLEN_MAX-1:0] imm;
  } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode and sign extension to XLEN.
// CSR zimm (type Z) decoding is enabled by defining IMM_ZICSR_EN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     inm,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate; inm[k] corresponds to instr[k+7].
  always_comb begin
    imm32   = 32'd0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm32 = {{20{inm[24]}}, inm[24:13]};
      IMM_S: imm32 = {{20{inm[24]}}, inm[24:18], inm[4:0]};
      IMM_B: imm32 = {{19{inm[24]}}, inm[24], inm[0], inm[23:18], inm[4:1], 1'b0};
      IMM_J: imm32 = {{11{inm[24]}}, inm[24], inm[12:5], inm[13], inm[23:14], 1'b0};
      IMM_U: imm32 = {inm[24:5], 12'd0};
`ifdef IMM_ZICSR_EN
      IMM_Z: imm32 = {27'd0, inm[12:8]};
`else
      IMM_Z: begin
        imm32   = 32'd0;
        illegal = 1'b1;
      end
`endif
      default: begin
        imm32   = 32'd0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; every 32-bit form is already correct at bit 31 for extension.
  always_comb begin
    imm        = {XLEN{imm32[31]}};
    imm[31:0]  = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer on a valid/ready
// handshake. Optional CSR zimm decoding is controlled by the IMM_ZICSR_EN macro.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inm,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  state_e   state_q, state_d;
  imm_res_t out_q, out_d;
  imm_res_t skid_q, skid_d;
  imm_res_t dec_res;
  logic     in_ready_q, in_ready_d;
  logic [XLEN-1:0] dec_imm;
  logic     dec_illegal;
  logic     push, pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inm     (inm),
    .imm_src (imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Pack the decoded request into the storage record.
  always_comb begin
    dec_res                  = '0;
    dec_res.illegal          = dec_illegal;
    dec_res.tag[TAG_W-1:0]   = in_tag;
    dec_res.imm[XLEN-1:0]    = dec_imm;
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state logic of the output/skid occupancy FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_FULL; else state_d = ST_EMPTY;
      ST_FULL: begin
        if (push && !pop)      state_d = ST_SKID;
        else if (!push && pop) state_d = ST_EMPTY;
        else                   state_d = ST_FULL;
      end
      ST_SKID: if (pop) state_d = ST_FULL; else state_d = ST_SKID;
      default: state_d = ST_EMPTY;
    endcase
  end

  // Datapath loads; in_ready is precomputed so it never sees out_ready combinationally.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    case (state_q)
      ST_EMPTY: if (push) out_d = dec_res; else out_d = out_q;
      ST_FULL: begin
        if (push && pop) out_d  = dec_res;
        else if (push)   skid_d = dec_res;
        else             out_d  = out_q;
      end
      ST_SKID: if (pop) out_d = skid_q; else out_d = out_q;
      default: out_d = out_q;
    endcase
    in_ready_d = (state_d != ST_SKID);
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Outputs; reset masks both handshakes so nothing transfers during reset.
  always_comb begin
    out_valid = (state_q != ST_EMPTY) && !reset;
    in_ready  = in_ready_q && !reset;
    imm_ext   = out_q.imm[XLEN-1:0];
    out_tag   = out_q.tag[TAG_W-1:0];
    illegal   = out_q.illegal;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (XLEN=32 main instance, XLEN=64 spot checks).
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             in_valid, in_ready, out_valid, out_ready, illegal;
  logic [24:0]      inm;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [31:0]      imm_ext;

  logic             v64, r64, ov64, ordy64, il64;
  logic [24:0]      inm64;
  logic [2:0]       src64;
  logic [TAG_W-1:0] tag64_i, tag64_o;
  logic [63:0]      imm64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inm(inm), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .imm_ext(imm_ext), .out_tag(out_tag), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(r64),
    .inm(inm64), .imm_src(src64), .in_tag(tag64_i), .out_valid(ov64),
    .out_ready(ordy64), .imm_ext(imm64), .out_tag(tag64_o), .illegal(il64)
  );

  typedef struct packed {
    logic             il;
    logic [TAG_W-1:0] tag;
    logic [63:0]      imm;
    logic             lat;
    logic [31:0]      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        acc     = 1'b0;
  logic        lat_mode = 1'b0;
  logic [63:0] next_imm = 64'd0;
  logic        next_il  = 1'b0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference decode from the architectural instruction fields.
  function automatic logic [64:0] ref_imm(input logic [24:0] f, input logic [2:0] src);
    logic [31:0] ins;
    logic [63:0] v;
    logic        il;
    ins = {f, 7'b0010011};
    il  = 1'b0;
    case (src)
      3'd0: v = {{52{ins[31]}}, ins[31:20]};
      3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: v = {{32{ins[31]}}, ins[31:12], 12'd0};
`ifdef IMM_ZICSR_EN
      3'd5: v = {59'd0, ins[19:15]};
`endif
      default: begin v = 64'd0; il = 1'b1; end
    endcase
    return {il, v};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare on every transfer out, enqueue on every transfer in.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      acc <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 64'd1, 64'd0);
        end else begin
          e_pop = sb.pop_front();
          check_eq("imm", {32'd0, imm_ext}, {32'd0, e_pop.imm[31:0]});
          check_eq("tag", {59'd0, out_tag}, {59'd0, e_pop.tag});
          check_eq("illegal", {63'd0, illegal}, {63'd0, e_pop.il});
          if (e_pop.lat) check_eq("latency", 64'(cyc - int'(e_pop.cyc)), 64'd1);
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{il: next_il, tag: in_tag, imm: next_imm, lat: lat_mode, cyc: 32'(cyc)});
      acc <= in_valid && in_ready;
    end
  end

  task automatic set_req(input logic [31:0] instr, input logic [2:0] src,
                         input logic [TAG_W-1:0] tag, input logic [63:0] eimm, input logic eil);
    inm      = instr[31:7];
    imm_src  = src;
    in_tag   = tag;
    next_imm = eimm;
    next_il  = eil;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [2:0] src,
                      input logic [TAG_W-1:0] tag, input logic [63:0] eimm, input logic eil);
    int n;
    @(posedge clk); #1;
    set_req(instr, src, tag, eimm, eil);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] ins64 [2];
    logic [63:0] exp64 [2];
    logic [2:0]  s64 [2];
    logic        r0;
    logic [2:0]  rsrc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inm = 25'd0; imm_src = 3'd0; in_tag = '0;
    v64 = 1'b0; ordy64 = 1'b1; inm64 = 25'd0; src64 = 3'd0; tag64_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_imm", {32'd0, imm_ext}, 64'd0);
    check_eq("rst_tag", {59'd0, out_tag}, 64'd0);
    check_eq("rst_illegal", {63'd0, illegal}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_rst", {63'd0, in_ready}, 64'd1);

    // Basic types with one-cycle latency into an empty pipe.
    lat_mode = 1'b1;
    send(32'hFFF00093, 3'b000, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(32'h123450B7, 3'b100, 5'd2, 64'h0000_0000_1234_5000, 1'b0);
    send(32'hFE000EE3, 3'b010, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h0080006F, 3'b011, 5'd4, 64'h0000_0000_0000_0008, 1'b0);
    send(32'hFE112E23, 3'b001, 5'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    lat_mode = 1'b0;

    send(32'hFFFFFFFF, 3'b111, 5'd6, 64'd0, 1'b1);
    send(32'hFFFFFFFF, 3'b110, 5'd7, 64'd0, 1'b1);
`ifdef IMM_ZICSR_EN
    send(32'h000FD073, 3'b101, 5'd8, 64'h1F, 1'b0);
`else
    send(32'h000FD073, 3'b101, 5'd8, 64'd0, 1'b1);
`endif
    repeat (3) @(posedge clk);

    // Backpressure: two accepted, third held until the skid drains.
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_req(32'h00100093, 3'b000, 5'd1, 64'd1, 1'b0);
    @(negedge clk); check_eq("bp_acc1", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(32'h00200093, 3'b000, 5'd2, 64'd2, 1'b0);
    @(negedge clk); check_eq("bp_acc2", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(32'hFFF00093, 3'b000, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_hold", {63'd0, in_ready}, 64'd0);
      check_eq("bp_valid", {63'd0, out_valid}, 64'd1);
      check_eq("bp_stable", {59'd0, out_tag}, 64'd1);
      if (k < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); check_eq("bp_gap1", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_gap2", {63'd0, out_valid}, 64'd1);
    check_eq("bp_acc3", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check_eq("bp_gap3", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk); check_eq("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset while both entries are occupied.
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_req(32'h00400093, 3'b000, 5'd4, 64'd4, 1'b0);
    @(posedge clk); #1;
    set_req(32'h00500093, 3'b000, 5'd5, 64'd5, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check_eq("skid_full", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_no_pop", {63'd0, out_valid}, 64'd0);
    check_eq("rst_rdy_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_rdy_high", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_tag", {59'd0, out_tag}, 64'd0);
    repeat (3) begin
      check_eq("no_stale", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end

    // XLEN=64 spot checks.
    ins64[0] = 32'h800000B7; s64[0] = 3'b100; exp64[0] = 64'hFFFF_FFFF_8000_0000;
    ins64[1] = 32'h7FF00093; s64[1] = 3'b000; exp64[1] = 64'h0000_0000_0000_07FF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      ins = ins64[k];
      inm64 = ins[31:7]; src64 = s64[k]; tag64_i = 5'(k + 9); v64 = 1'b1;
      @(negedge clk); check_eq("x64_ready", {63'd0, r64}, 64'd1);
      @(posedge clk); #1;
      v64 = 1'b0;
      @(negedge clk);
      check_eq("x64_valid", {63'd0, ov64}, 64'd1);
      check_eq("x64_imm", imm64, exp64[k]);
      check_eq("x64_tag", {59'd0, tag64_o}, 64'(k + 9));
      check_eq("x64_illegal", {63'd0, il64}, 64'd0);
    end

    // Random traffic with held requests and an out_ready toggle probe.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        ins  = $urandom;
        rsrc = 3'($urandom_range(7));
        in_valid = ($urandom_range(3) != 0);
        inm      = ins[31:7];
        imm_src  = rsrc;
        in_tag   = 5'($urandom);
        {next_il, next_imm} = ref_imm(ins[31:7], rsrc);
      end
      out_ready = ($urandom_range(9) < 7);
      r0 = in_ready;
      #1 out_ready = ~out_ready;
      #1 check_eq("rdy_comb", {63'd0, in_ready}, {63'd0, r0});
      out_ready = ~out_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the RV32/RV64 core. It accepts the upper 25 instruction bits plus an immediate-type selector over a valid/ready handshake, decodes and sign-extends to XLEN, and presents the result one cycle later through a registered output backed by a one-entry skid buffer. It adds U-type and optional CSR zimm decoding, an illegal-type flag, and a pass-through tag.

## Interface
- XLEN, 32: output width; legal values are 32 and 64.
- TAG_W, 5: width of the sideband tag carried with each immediate (typically rd).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- inm  in  25  instruction bits [31:7]; inm[24] is instr[31].
- imm_src  in  3  immediate type; encodings are in imm_pkg.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- imm_ext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag paired with imm_ext.
- illegal  out  1  imm_src was unsupported; imm_ext is 0.

## Operation
- Decode, sign bit inm[24] replicated to XLEN:
  - I (000): inm[24:13].
  - S (001): {inm[24:18], inm[4:0]}.
  - B (010): {inm[24], inm[0], inm[23:18], inm[4:1], 0}.
  - J (011): {inm[24], inm[12:5], inm[13], inm[23:14], 0}.
  - U (100): {inm[24:5], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - Z (101): see Configuration.
  - 110/111: imm_ext=0, illegal=1.
- Transfer rules:
  - A transfer in occurs when in_valid && in_ready.
  - A transfer out occurs when out_valid && out_ready.
  - Decode is performed on input; registers hold the decoded {imm_ext, tag, illegal}.
- State machine:
  - EMPTY: out_valid=0. A transfer in moves to FULL.
  - FULL: out_valid=1, skid empty.
    - Transfer in and no transfer out: entry goes to the skid register; move to SKID.
    - Transfer in and transfer out together: output reloads; stay FULL.
    - Transfer out only: move to EMPTY.
  - SKID: both registers valid, in_ready=0.
    - Transfer out: skid entry moves to the output register; move to FULL.
- in_ready = (state != SKID), driven from a register with no combinational path from out_ready.
- Output fields stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO. No request is dropped or duplicated.

## Timing
- Latency: a transfer in at cycle N gives out_valid at N+1 if the output register is empty.
- Throughput: one result per cycle while out_ready=1.
- Reset values:
  - State is EMPTY, with out_valid=0, imm_ext=0, out_tag=0, illegal=0.
  - in_ready=1 from the first cycle after reset is deasserted; in_ready=0 while reset is high.
- Reset mid-operation discards both entries in the same edge, and no transfer out completes in that cycle.
- in_valid while reset is high is ignored.

## Configuration
- IMM_ZICSR_EN defined: imm_src 101 yields imm_ext = zero-extended inm[12:8] (instr[19:15]) and illegal=0.
- IMM_ZICSR_EN undefined: 101 is treated like 110/111, giving imm_ext=0 and illegal=1.

## Structure
- Package imm_pkg holds:
  - the imm_src localparams IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z;
  - the state encoding for EMPTY, FULL and SKID;
  - a packed result struct {illegal, tag, imm}.
- Sub-module imm_decode holds the purely combinational decode, parametrised by XLEN. imm_gen_pipe instantiates it once, on the input side.

## Test plan
- **Basic types, XLEN=32, out_ready=1:**
  - instr 0xFFF00093 (I) -> imm_ext 0xFFFFFFFF one cycle later.
  - 0x123450B7 (U) -> 0x12345000.
  - 0xFE000EE3 (B) -> 0xFFFFFFFC.
  - 0x0080006F (J) -> 0x00000008.
- **XLEN=64:** U instr 0x800000B7 -> 0xFFFFFFFF80000000; I instr 0x7FF00093 -> 0x00000000000007FF.
- **Backpressure:** out_ready=0 with three back-to-back requests tagged 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready drops after the second acceptance, and request 3 is held until space frees.
  - Releasing out_ready yields tags 1, 2, 3 in order with no gaps.
- **Illegal type:** imm_src 111 -> illegal=1, imm_ext=0.
  - imm_src 101 with instr 0x000FD073 (rs1 field 31) gives 0x1F with IMM_ZICSR_EN defined.
  - Without the macro, the same input gives illegal=1.
- **Reset in SKID state:** assert reset for one cycle -> out_valid=0 next cycle, in_ready=1 after release, and no stale result appears.
- **Simultaneous push/pop in FULL:** random in_valid/out_ready over 1000 cycles.
  - A scoreboard matches the reference decode and order.
  - in_ready never depends combinationally on out_ready.
